// File: rtl/mmio_pkg.sv
// Shared definitions for the processor's external-bus peripherals: address windows,
// timer register offsets and the timer state encoding.
package mmio_pkg;

  // Address window select, ADDR[8:7]
  localparam logic [1:0] WIN_RAM   = 2'b00;
  localparam logic [1:0] WIN_LED   = 2'b01;
  localparam logic [1:0] WIN_TIMER = 2'b10;

  // Timer register offsets, ADDR[1:0]
  localparam logic [1:0] REG_LOAD   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // CTRL / STATUS bit positions
  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_AUTO_BIT   = 1;
  localparam int unsigned STAT_EXPIRE_BIT = 0;

  typedef enum logic [1:0] {
    IDLE,
    COUNTING,
    HALTED
  } timer_state_t;

  function automatic logic win_hit(input logic [8:0] addr, input logic [1:0] win);
    return addr[8:7] == win;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the clock into one-cycle ticks every PRESC_DIV enabled cycles.
// clr restarts the division so the first tick lands PRESC_DIV cycles later.
module timer_prescaler #(
  parameter int unsigned PRESC_DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESC_DIV - 1);

  logic [PW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer: address decode, LOAD/COUNT/CTRL/STATUS registers,
// run-control FSM and a registered read port matching RAM read latency.
module mmio_timer
  import mmio_pkg::*;
#(
  parameter int unsigned DATA_W    = 9,
  parameter int unsigned PRESC_DIV = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [8:0]        ADDR,
  input  logic [DATA_W-1:0] DOUT,
  input  logic              W,
  output logic [DATA_W-1:0] RDATA,
  output logic              RSEL,
  output logic              EXPIRED,
  output logic              IRQ
);

  timer_state_t      state_q;
  logic [DATA_W-1:0] load_q;
  logic [DATA_W-1:0] count_q;
  logic              ctrl_en_q;
  logic              ctrl_auto_q;
  logic              expired_q;
  logic              irq_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rsel_q;

  logic              hit;
  logic              wr_load;
  logic              wr_ctrl;
  logic              wr_status;
  logic              rd;
  logic              tick;
  logic              expire;
  logic [DATA_W-1:0] rd_data;

  // ADDR[6:2] is deliberately not decoded; the register file aliases across the window.
  logic unused_addr;
  assign unused_addr = ^ADDR[6:2];

  assign hit       = win_hit(ADDR, WIN_TIMER);
  assign wr_load   = W && hit && (ADDR[1:0] == REG_LOAD);
  assign wr_ctrl   = W && hit && (ADDR[1:0] == REG_CTRL);
  assign wr_status = W && hit && (ADDR[1:0] == REG_STATUS);
  assign rd        = !W && hit;

  timer_prescaler #(
    .PRESC_DIV(PRESC_DIV)
  ) u_prescaler (
    .CLK (CLK),
    .RST (RST),
    .clr (wr_ctrl),
    .en  (state_q == COUNTING),
    .tick(tick)
  );

  // A CTRL write on the expiry edge takes precedence: the restart/stop wins outright.
  assign expire = (state_q == COUNTING) && tick && (count_q == '0) && !wr_ctrl;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      count_q     <= '0;
      ctrl_en_q   <= 1'b0;
      ctrl_auto_q <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en_q   <= DOUT[CTRL_EN_BIT];
      ctrl_auto_q <= DOUT[CTRL_AUTO_BIT];
      if (DOUT[CTRL_EN_BIT]) begin
        state_q <= COUNTING;
        count_q <= load_q;
      end else begin
        state_q <= IDLE;
      end
    end else begin
      unique case (state_q)
        COUNTING: begin
          if (tick) begin
            if (count_q != '0) begin
              count_q <= count_q - DATA_W'(1);
            end else if (ctrl_auto_q) begin
              count_q <= load_q;
            end else begin
              ctrl_en_q <= 1'b0;
              state_q   <= HALTED;
            end
          end
        end
        IDLE, HALTED: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      load_q    <= '0;
      expired_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      irq_q <= expire;
      if (wr_load) begin
        load_q <= DOUT;
      end
      // Set beats a simultaneous write-one-to-clear.
      if (expire) begin
        expired_q <= 1'b1;
      end else if (wr_status && DOUT[STAT_EXPIRE_BIT]) begin
        expired_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (ADDR[1:0])
      REG_LOAD:   rd_data = load_q;
      REG_COUNT:  rd_data = count_q;
      REG_CTRL: begin
        rd_data[CTRL_EN_BIT]   = ctrl_en_q;
        rd_data[CTRL_AUTO_BIT] = ctrl_auto_q;
      end
      REG_STATUS: rd_data[STAT_EXPIRE_BIT] = expired_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata_q <= '0;
      rsel_q  <= 1'b0;
    end else begin
      rsel_q <= rd;
      if (rd) begin
        rdata_q <= rd_data;
      end
    end
  end

  assign RDATA   = rdata_q;
  assign RSEL    = rsel_q;
  assign EXPIRED = expired_q;
  assign IRQ     = irq_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer with PRESC_DIV=4: reset, one-shot, auto-reload, W1C collision,
// decode isolation, restart and mid-run LOAD change / reset.
module tb_mmio_timer;

  logic       CLK = 1'b0;
  logic       RST;
  logic [8:0] ADDR;
  logic [8:0] DOUT;
  logic       W;
  logic [8:0] RDATA;
  logic       RSEL;
  logic       EXPIRED;
  logic       IRQ;

  int checks   = 0;
  int failures = 0;

  localparam logic [8:0] A_LOAD   = 9'h100;
  localparam logic [8:0] A_COUNT  = 9'h101;
  localparam logic [8:0] A_CTRL   = 9'h102;
  localparam logic [8:0] A_STATUS = 9'h103;

  mmio_timer #(
    .DATA_W   (9),
    .PRESC_DIV(4)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .ADDR   (ADDR),
    .DOUT   (DOUT),
    .W      (W),
    .RDATA  (RDATA),
    .RSEL   (RSEL),
    .EXPIRED(EXPIRED),
    .IRQ    (IRQ)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_wr(input logic [8:0] a, input logic [8:0] d);
    ADDR = a;
    DOUT = d;
    W    = 1'b1;
    cyc();
    W    = 1'b0;
    ADDR = 9'h000;
    DOUT = 9'h000;
  endtask

  task automatic bus_rd(input logic [8:0] a, output logic [8:0] d, output logic s);
    ADDR = a;
    W    = 1'b0;
    cyc();
    d    = RDATA;
    s    = RSEL;
    ADDR = 9'h000;
  endtask

  task automatic test_reset();
    logic [8:0] d;
    logic       s;
    RST  = 1'b1;
    W    = 1'b0;
    ADDR = 9'h000;
    DOUT = 9'h000;
    cyc();
    cyc();
    checks++;
    if (RDATA !== 9'h000 || RSEL !== 1'b0 || EXPIRED !== 1'b0 || IRQ !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got rdata=%h rsel=%b exp=%b irq=%b want all 0",
               RDATA, RSEL, EXPIRED, IRQ);
    end
    RST = 1'b0;
    for (int r = 0; r < 4; r++) begin
      bus_rd(A_LOAD + 9'(r), d, s);
      checks++;
      if (d !== 9'h000 || s !== 1'b1) begin
        failures++;
        $display("FAIL reset_read reg=%0d got data=%h rsel=%b want data=000 rsel=1", r, d, s);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [8:0] d;
    logic       s;
    bus_wr(A_LOAD, 9'd3);
    bus_wr(A_CTRL, 9'd1);
    for (int k = 1; k <= 24; k++) begin
      cyc();
      checks++;
      if (IRQ !== (k == 16)) begin
        failures++;
        $display("FAIL one_shot_irq cycle=%0d got irq=%b want %b", k, IRQ, (k == 16));
      end
    end
    bus_rd(A_CTRL, d, s);
    checks++;
    if (d !== 9'h000) begin
      failures++;
      $display("FAIL one_shot_ctrl got %h want 000", d);
    end
    bus_rd(A_COUNT, d, s);
    checks++;
    if (d !== 9'h000) begin
      failures++;
      $display("FAIL one_shot_count got %h want 000", d);
    end
    bus_rd(A_STATUS, d, s);
    checks++;
    if (d !== 9'h001 || EXPIRED !== 1'b1) begin
      failures++;
      $display("FAIL one_shot_status got status=%h expired=%b want 001/1", d, EXPIRED);
    end
  endtask

  task automatic test_auto_reload();
    logic [8:0] want;
    bus_wr(A_STATUS, 9'd1);
    bus_wr(A_LOAD, 9'd1);
    bus_wr(A_CTRL, 9'd3);
    ADDR = A_COUNT;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      want = (((k - 1) % 8) < 4) ? 9'd1 : 9'd0;
      checks++;
      if (IRQ !== ((k % 8) == 0)) begin
        failures++;
        $display("FAIL auto_irq cycle=%0d got irq=%b want %b", k, IRQ, ((k % 8) == 0));
      end
      checks++;
      if (RDATA !== want || RSEL !== 1'b1) begin
        failures++;
        $display("FAIL auto_count cycle=%0d got count=%h rsel=%b want %h/1", k, RDATA, RSEL, want);
      end
    end
    bus_wr(A_CTRL, 9'd0);
  endtask

  task automatic test_w1c_collision();
    bus_wr(A_LOAD, 9'd0);
    bus_wr(A_STATUS, 9'd1);
    checks++;
    if (EXPIRED !== 1'b0) begin
      failures++;
      $display("FAIL w1c_clear got expired=%b want 0", EXPIRED);
    end
    bus_wr(A_CTRL, 9'd3);
    cyc();
    cyc();
    cyc();
    checks++;
    if (EXPIRED !== 1'b0) begin
      failures++;
      $display("FAIL w1c_pre got expired=%b want 0", EXPIRED);
    end
    bus_wr(A_STATUS, 9'd1);
    checks++;
    if (IRQ !== 1'b1 || EXPIRED !== 1'b1) begin
      failures++;
      $display("FAIL w1c_collision got irq=%b expired=%b want 1/1", IRQ, EXPIRED);
    end
    bus_wr(A_CTRL, 9'd0);
    bus_wr(A_STATUS, 9'd1);
    checks++;
    if (EXPIRED !== 1'b0) begin
      failures++;
      $display("FAIL w1c_later got expired=%b want 0", EXPIRED);
    end
  endtask

  task automatic test_decode();
    logic [8:0] d;
    logic       s;
    logic [8:0] foreign [5] = '{9'h000, 9'h080, 9'h082, 9'h182, 9'h003};
    bus_wr(A_LOAD, 9'd5);
    bus_wr(A_CTRL, 9'd1);
    bus_wr(A_CTRL, 9'd0);
    for (int i = 0; i < 5; i++) begin
      bus_wr(foreign[i], 9'h1FF);
      checks++;
      if (RSEL !== 1'b0) begin
        failures++;
        $display("FAIL decode_rsel addr=%h got rsel=%b want 0", foreign[i], RSEL);
      end
    end
    bus_wr(A_COUNT, 9'h000);
    bus_rd(A_LOAD, d, s);
    checks++;
    if (d !== 9'd5) begin
      failures++;
      $display("FAIL decode_load got %h want 005", d);
    end
    bus_rd(A_CTRL, d, s);
    checks++;
    if (d !== 9'd0 || IRQ !== 1'b0) begin
      failures++;
      $display("FAIL decode_ctrl got ctrl=%h irq=%b want 000/0", d, IRQ);
    end
    bus_rd(A_STATUS, d, s);
    checks++;
    if (d !== 9'd0) begin
      failures++;
      $display("FAIL decode_status got %h want 000", d);
    end
    bus_rd(A_COUNT, d, s);
    checks++;
    if (d !== 9'd5 || s !== 1'b1) begin
      failures++;
      $display("FAIL decode_count got count=%h rsel=%b want 005/1", d, s);
    end
    bus_rd(9'h17D, d, s);
    checks++;
    if (d !== 9'd5 || s !== 1'b1) begin
      failures++;
      $display("FAIL decode_alias got count=%h rsel=%b want 005/1", d, s);
    end
    bus_rd(A_LOAD, d, s);
    bus_rd(9'h001, d, s);
    checks++;
    if (d !== 9'd5 || s !== 1'b0) begin
      failures++;
      $display("FAIL decode_hold got rdata=%h rsel=%b want 005/0", d, s);
    end
  endtask

  task automatic test_restart();
    bus_wr(A_LOAD, 9'd1);
    bus_wr(A_CTRL, 9'd1);
    for (int k = 1; k <= 5; k++) cyc();
    bus_wr(A_CTRL, 9'd1);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      checks++;
      if (IRQ !== (k == 8)) begin
        failures++;
        $display("FAIL restart_irq cycle=%0d got irq=%b want %b", k, IRQ, (k == 8));
      end
    end
  endtask

  task automatic test_mid_run();
    logic [8:0] d;
    logic       s;
    bus_wr(A_STATUS, 9'd1);
    bus_wr(A_LOAD, 9'd5);
    bus_wr(A_CTRL, 9'd3);
    for (int k = 1; k <= 47; k++) begin
      if (k == 5) begin
        ADDR = A_LOAD;
        DOUT = 9'd2;
        W    = 1'b1;
      end else begin
        ADDR = 9'h000;
        DOUT = 9'h000;
        W    = 1'b0;
      end
      cyc();
      checks++;
      if (IRQ !== (k == 24 || k == 36)) begin
        failures++;
        $display("FAIL midrun_irq cycle=%0d got irq=%b want %b", k, IRQ, (k == 24 || k == 36));
      end
    end
    W   = 1'b0;
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    checks++;
    if (IRQ !== 1'b0 || EXPIRED !== 1'b0 || RSEL !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset got irq=%b expired=%b rsel=%b want 0/0/0", IRQ, EXPIRED, RSEL);
    end
    bus_rd(A_COUNT, d, s);
    checks++;
    if (d !== 9'd0) begin
      failures++;
      $display("FAIL midrun_count got %h want 000", d);
    end
    for (int k = 1; k <= 16; k++) begin
      cyc();
      checks++;
      if (IRQ !== 1'b0) begin
        failures++;
        $display("FAIL midrun_quiet cycle=%0d got irq=%b want 0", k, IRQ);
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_w1c_collision();
    test_decode();
    test_restart();
    test_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
